// File: rtl/fpu_lza_normalizer.sv
// Post-adder normalizer: a coarse shift by the LZA count, then a 1-bit
// correction, exponent update and guard/round/sticky extraction.
// Two-stage valid/ready pipeline, where S2 holds the registered result.
module fpu_lza_normalizer #(
  parameter int unsigned SUM_W = 49,
  parameter int unsigned EXP_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] in_sum,
  input  logic [5:0]       in_lza,
  input  logic [EXP_W-1:0] in_exp,
  input  logic             in_sticky,
  input  logic             in_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [23:0]      out_mant,
  output logic [2:0]       out_grs,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_sign,
  output logic             out_zero,
  output logic             out_tiny,
  output logic             out_err
);

  localparam int unsigned MANT_W = 24;
  localparam int unsigned LOW_W  = SUM_W - MANT_W - 2;
  localparam int unsigned WIDE_W = 2 * SUM_W;
  localparam logic [6:0]  LZA_CAP = 7'(SUM_W);

  // Pipeline control
  logic w_in_fire;
  logic w_s2_adv;

  // S1 state
  logic             r_s1_valid;
  logic [SUM_W-1:0] r_s1_shifted;
  logic             r_s1_ovf;
  logic             r_s1_nz;
  logic [EXP_W-1:0] r_s1_exp;
  logic             r_s1_sticky;
  logic             r_s1_sign;

  // S2 state (the registered outputs)
  logic              r_s2_valid;
  logic [MANT_W-1:0] r_mant;
  logic [2:0]        r_grs;
  logic [EXP_W-1:0]  r_exp;
  logic              r_sign;
  logic              r_zero;
  logic              r_tiny;
  logic              r_err;

  // S1 combinational
  logic [6:0]        w_shamt;
  logic [WIDE_W-1:0] w_wide;
  logic              w_ovf;
  logic              w_nz;
  logic [EXP_W-1:0]  w_exp1;

  // S2 combinational
  logic              w_corr;
  logic [SUM_W-1:0]  w_final;
  logic [MANT_W-1:0] w_mant;
  logic [2:0]        w_grs;
  logic [EXP_W-1:0]  w_exp2;
  logic              w_tiny;
  logic              w_err;

  // S1 can take a beat whenever it is empty or will hand its beat to S2
  assign in_ready  = ~r_s1_valid | ~r_s2_valid | out_ready;
  assign w_in_fire = in_valid & in_ready;
  assign w_s2_adv  = r_s1_valid & (~r_s2_valid | out_ready);

  // Coarse shift; the upper half of the wide result catches over-shifted ones
  assign w_shamt = ({1'b0, in_lza} > LZA_CAP) ? LZA_CAP : {1'b0, in_lza};
  assign w_wide  = {{SUM_W{1'b0}}, in_sum} << w_shamt;
  assign w_ovf   = |w_wide[WIDE_W-1:SUM_W];
  assign w_nz    = |in_sum;
  assign w_exp1  = in_exp - EXP_W'(in_lza);

  // S1 valid flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
    end else if (w_s2_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // S1 data capture on an accepted input beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_shifted <= '0;
      r_s1_ovf     <= 1'b0;
      r_s1_nz      <= 1'b0;
      r_s1_exp     <= '0;
      r_s1_sticky  <= 1'b0;
      r_s1_sign    <= 1'b0;
    end else if (w_in_fire) begin
      r_s1_shifted <= w_wide[SUM_W-1:0];
      r_s1_ovf     <= w_ovf;
      r_s1_nz      <= w_nz;
      r_s1_exp     <= w_exp1;
      r_s1_sticky  <= in_sticky;
      r_s1_sign    <= in_sign;
    end
  end

  // Fine correction, exponent adjust and GRS extraction; zero input forced clean
  always_comb begin
    w_corr  = ~r_s1_shifted[SUM_W-1] & r_s1_nz;
    w_final = w_corr ? {r_s1_shifted[SUM_W-2:0], 1'b0} : r_s1_shifted;
    w_mant  = w_final[SUM_W-1 -: MANT_W];
    w_grs   = {w_final[SUM_W-MANT_W-1], w_final[SUM_W-MANT_W-2],
               (|w_final[LOW_W-1:0]) | r_s1_sticky};
    w_exp2  = r_s1_exp - EXP_W'(w_corr);
    w_tiny  = w_exp2[EXP_W-1] | (w_exp2 == '0);
    w_err   = r_s1_ovf | (r_s1_nz & ~w_final[SUM_W-1]);
    if (!r_s1_nz) begin
      w_mant = '0;
      w_grs  = {2'b00, r_s1_sticky};
      w_exp2 = '0;
      w_tiny = 1'b0;
      w_err  = 1'b0;
    end
  end

  // S2 valid flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= 1'b1;
    end else if (out_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  // S2 result registers, held stable while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mant <= '0;
      r_grs  <= '0;
      r_exp  <= '0;
      r_sign <= 1'b0;
      r_zero <= 1'b0;
      r_tiny <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_s2_adv) begin
      r_mant <= w_mant;
      r_grs  <= w_grs;
      r_exp  <= w_exp2;
      r_sign <= r_s1_sign;
      r_zero <= ~r_s1_nz;
      r_tiny <= w_tiny;
      r_err  <= w_err;
    end
  end

  assign out_valid = r_s2_valid;
  assign out_mant  = r_mant;
  assign out_grs   = r_grs;
  assign out_exp   = r_exp;
  assign out_sign  = r_sign;
  assign out_zero  = r_zero;
  assign out_tiny  = r_tiny;
  assign out_err   = r_err;

endmodule

// File: tb/tb_fpu_lza_normalizer.sv
// Directed bench for fpu_lza_normalizer: single-beat vectors, backpressure
// stream and mid-flight reset.
module tb_fpu_lza_normalizer;

  localparam int unsigned SUM_W = 49;
  localparam int unsigned EXP_W = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [SUM_W-1:0] in_sum;
  logic [5:0]       in_lza;
  logic [EXP_W-1:0] in_exp;
  logic             in_sticky;
  logic             in_sign;
  logic             out_valid;
  logic             out_ready;
  logic [23:0]      out_mant;
  logic [2:0]       out_grs;
  logic [EXP_W-1:0] out_exp;
  logic             out_sign;
  logic             out_zero;
  logic             out_tiny;
  logic             out_err;

  int n_checks = 0;
  int n_fail   = 0;

  fpu_lza_normalizer #(.SUM_W(SUM_W), .EXP_W(EXP_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_lza(in_lza), .in_exp(in_exp),
    .in_sticky(in_sticky), .in_sign(in_sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_grs(out_grs), .out_exp(out_exp),
    .out_sign(out_sign), .out_zero(out_zero), .out_tiny(out_tiny),
    .out_err(out_err)
  );

  always #5 clk = ~clk;

  // Single comparison point
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One beat through an idle pipeline with out_ready high; 2-cycle latency
  task automatic run_vec(input string tag, input logic [SUM_W-1:0] sum, input logic [5:0] lza,
                         input logic [EXP_W-1:0] e, input logic st, input logic sg,
                         input logic [23:0] x_mant, input logic [2:0] x_grs,
                         input logic [EXP_W-1:0] x_exp, input logic x_zero,
                         input logic x_tiny, input logic x_err, input logic chk_data);
    @(negedge clk);
    out_ready = 1'b1;
    in_sum = sum; in_lza = lza; in_exp = e; in_sticky = st; in_sign = sg;
    in_valid = 1'b1;
    #1;
    check_eq({tag, ".rdy"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq({tag, ".lat1"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    check_eq({tag, ".vld"},  64'(out_valid), 64'd1);
    check_eq({tag, ".zero"}, 64'(out_zero), 64'(x_zero));
    check_eq({tag, ".err"},  64'(out_err), 64'(x_err));
    check_eq({tag, ".sign"}, 64'(out_sign), 64'(sg));
    if (chk_data) begin
      check_eq({tag, ".mant"}, 64'(out_mant), 64'(x_mant));
      check_eq({tag, ".grs"},  64'(out_grs), 64'(x_grs));
      check_eq({tag, ".exp"},  64'(out_exp), 64'(x_exp));
      check_eq({tag, ".tiny"}, 64'(out_tiny), 64'(x_tiny));
    end
  endtask

  int          tx;
  int          rx;
  logic [23:0] saved_mant;
  logic        seen;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_lza = '0; in_exp = '0;
    in_sticky = 1'b0; in_sign = 1'b0; out_ready = 1'b0;
    #1;
    check_eq("rst.valid", 64'(out_valid), 64'd0);
    check_eq("rst.ready", 64'(in_ready), 64'd1);
    check_eq("rst.mant",  64'(out_mant), 64'd0);
    check_eq("rst.exp",   64'(out_exp), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // tag, sum, lza, exp, sticky, sign, mant, grs, exp_out, zero, tiny, err, chk_data
    run_vec("exact",    49'h0_8000_0000_0000, 6'd1,  10'd5,   1'b0, 1'b0, 24'h800000, 3'b000, 10'd4,   1'b0, 1'b0, 1'b0, 1'b1);
    run_vec("corr",     49'h0_4000_0000_0001, 6'd1,  10'd5,   1'b0, 1'b1, 24'h800000, 3'b001, 10'd3,   1'b0, 1'b0, 1'b0, 1'b1);
    run_vec("ovf",      49'h0_8000_0000_0000, 6'd2,  10'd5,   1'b0, 1'b0, 24'h0,      3'b000, 10'd0,   1'b0, 1'b0, 1'b1, 1'b0);
    run_vec("zero",     49'h0,                6'd49, 10'd7,   1'b1, 1'b1, 24'h0,      3'b001, 10'd0,   1'b1, 1'b0, 1'b0, 1'b1);
    run_vec("tiny0",    49'h1_0000_0000_0000, 6'd0,  10'd0,   1'b0, 1'b0, 24'h800000, 3'b000, 10'd0,   1'b0, 1'b1, 1'b0, 1'b1);
    run_vec("ones",     49'h1_FFFF_FFFF_FFFF, 6'd0,  10'h3FD, 1'b0, 1'b1, 24'hFFFFFF, 3'b111, 10'h3FD, 1'b0, 1'b1, 1'b0, 1'b1);
    run_vec("guard",    49'h1_0000_0100_0000, 6'd0,  10'd10,  1'b0, 1'b0, 24'h800000, 3'b100, 10'd10,  1'b0, 1'b0, 1'b0, 1'b1);
    run_vec("round",    49'h0_0100_0000_8000, 6'd8,  10'd20,  1'b0, 1'b0, 24'h800000, 3'b010, 10'd12,  1'b0, 1'b0, 1'b0, 1'b1);
    run_vec("under2",   49'h0_2000_0000_0000, 6'd1,  10'd5,   1'b0, 1'b0, 24'h0,      3'b000, 10'd0,   1'b0, 1'b0, 1'b1, 1'b0);
    run_vec("lza48",    49'h0_0000_0000_0001, 6'd48, 10'd50,  1'b0, 1'b0, 24'h800000, 3'b000, 10'd2,   1'b0, 1'b0, 1'b0, 1'b1);
    run_vec("lza49",    49'h0_0000_0000_0001, 6'd49, 10'd50,  1'b0, 1'b0, 24'h0,      3'b000, 10'd0,   1'b0, 1'b0, 1'b1, 1'b0);
    run_vec("lza63",    49'h0_0000_0000_0001, 6'd63, 10'd50,  1'b0, 1'b0, 24'h0,      3'b000, 10'd0,   1'b0, 1'b0, 1'b1, 1'b0);
    run_vec("expwrap",  49'h0_8000_0000_0000, 6'd0,  10'h200, 1'b0, 1'b0, 24'h800000, 3'b000, 10'h1FF, 1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure stream: 4 beats, out_ready low for cycles 0..4
    tx = 0; rx = 0; saved_mant = '0;
    for (int c = 0; c < 40 && rx < 4; c++) begin
      @(negedge clk);
      out_ready = (c >= 5);
      in_valid  = (tx < 4);
      in_sum    = 49'h1_0000_0000_0000 | (49'(tx + 1) << 25);
      in_lza    = 6'd0;
      in_exp    = 10'(tx + 1);
      in_sticky = 1'b0;
      in_sign   = 1'b0;
      #1;
      if (c == 2) begin
        check_eq("bp.in_ready", 64'(in_ready), 64'd0);
        check_eq("bp.accepted", 64'(tx), 64'd2);
        saved_mant = out_mant;
      end
      if (c == 3 || c == 4) begin
        check_eq("bp.hold_vld",  64'(out_valid), 64'd1);
        check_eq("bp.hold_mant", 64'(out_mant), 64'(saved_mant));
      end
      if (out_valid && out_ready) begin
        check_eq("bp.mant", 64'(out_mant), 64'(24'h800000 | 24'(rx + 1)));
        check_eq("bp.exp",  64'(out_exp), 64'(10'(rx + 1)));
        rx++;
      end
      if (in_valid && in_ready) tx++;
    end
    check_eq("bp.count", 64'(rx), 64'd4);
    @(negedge clk);
    in_valid = 1'b0;

    // Fill both stages, then reset asynchronously mid-cycle
    out_ready = 1'b0;
    in_sum = 49'h1_0000_0000_0000; in_lza = 6'd0; in_exp = 10'd1; in_valid = 1'b1;
    @(negedge clk);
    in_sum = 49'h1_8000_0000_0000;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("rst2.full", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst2.valid", 64'(out_valid), 64'd0);
    check_eq("rst2.ready", 64'(in_ready), 64'd1);
    check_eq("rst2.mant",  64'(out_mant), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    check_eq("rst2.stale", 64'(seen), 64'd0);
    run_vec("post_rst", 49'h0_8000_0000_0000, 6'd1, 10'd5, 1'b0, 1'b1, 24'h800000, 3'b000, 10'd4, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
